// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   F3_*         : RISC-V funct3 encodings for load/store access size
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational little-endian lane steering for one 32-bit memory word.
//   write      : 1 = store, 0 = load
//   func3      : RISC-V access size / signedness
//   addr_lo    : byte offset within the word
//   wdata      : right-aligned store data
//   old_word   : current contents of the addressed word
//   store_word : old_word with the stored lanes replaced (old_word on error)
//   load_data  : extended load result (0 for stores and errors)
//   err        : misaligned access or illegal funct3
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        write,
   input  logic [2:0]  func3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] old_word,
   output logic [31:0] store_word,
   output logic [31:0] load_data,
   output logic        err
);

   logic [7:0]  old_byte [4];
   logic [3:0]  byte_en;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Per-lane merge: a byte store replicates wdata[7:0] onto every lane and a
   // half store replicates wdata[15:0], so the enable alone picks the lane.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_wdata;
         assign old_byte[gi] = old_word[8*gi +: 8];
         assign lane_wdata   = (func3 == F3_B) ? wdata[7:0] :
                               (func3 == F3_H) ? wdata[8*(gi%2) +: 8] :
                                                 wdata[8*gi +: 8];
         assign store_word[8*gi +: 8] = byte_en[gi] ? lane_wdata : old_byte[gi];
      end
   endgenerate

   always_comb begin
      err = 1'b0;
      case (func3)
         F3_B:  err = 1'b0;
         F3_H:  err = addr_lo[0];
         F3_W:  err = (addr_lo != 2'b00);
         F3_BU: err = write;
         F3_HU: err = write | addr_lo[0];
         default: err = 1'b1;
      endcase
   end

   always_comb begin
      byte_en = 4'b0000;
      if (write && !err) begin
         case (func3)
            F3_B:    byte_en[addr_lo] = 1'b1;
            F3_H:    byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
         endcase
      end
   end

   assign sel_byte = old_byte[addr_lo];
   assign sel_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];

   always_comb begin
      load_data = 32'd0;
      if (!write && !err) begin
         case (func3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = old_word;
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = 32'd0;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with valid/ready request handshake and a fixed
// number of wait states before each one-cycle response pulse.
//   clk, reset (async, active-low)
//   req_valid/req_ready            : request handshake
//   req_write/req_addr/req_wdata/req_func3 : request fields, sampled on accept
//   rsp_valid/rsp_rdata/rsp_err    : registered response, held between pulses
//   busy                           : a request is in flight
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [2:0]            req_func3,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int         WORDS     = 2 ** (DM_ADDRESS - 2);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   dmem_state_t           state_reg;
   logic [3:0]            cnt_reg;
   logic                  lat_write_reg;
   logic [DM_ADDRESS-1:0] lat_addr_reg;
   logic [DATA_W-1:0]     lat_wdata_reg;
   logic [2:0]            lat_func3_reg;
   logic                  req_ready_reg;
   logic                  rsp_valid_reg;
   logic [DATA_W-1:0]     rsp_rdata_reg;
   logic                  rsp_err_reg;
   logic                  busy_reg;

   logic [DATA_W-1:0]     mem [WORDS];

   // With zero wait states the edge that accepts also enters RESP, so the
   // access must use the live request fields rather than the latch.
   logic                  use_live;
   logic                  op_write;
   logic [DM_ADDRESS-1:0] op_addr;
   logic [DATA_W-1:0]     op_wdata;
   logic [2:0]            op_func3;
   logic                  enter_resp;
   logic                  mem_we;
   logic [DATA_W-1:0]     old_word;
   logic [DATA_W-1:0]     store_word;
   logic [DATA_W-1:0]     load_data;
   logic                  op_err;

   assign use_live   = (state_reg == IDLE);
   assign op_write   = use_live ? req_write : lat_write_reg;
   assign op_addr    = use_live ? req_addr  : lat_addr_reg;
   assign op_wdata   = use_live ? req_wdata : lat_wdata_reg;
   assign op_func3   = use_live ? req_func3 : lat_func3_reg;

   assign enter_resp = ((state_reg == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                       ((state_reg == WAIT) && (cnt_reg == 4'd0));

   assign old_word   = mem[op_addr[DM_ADDRESS-1:2]];

   dmem_lane_align u_lane_align (
      .write      (op_write),
      .func3      (op_func3),
      .addr_lo    (op_addr[1:0]),
      .wdata      (op_wdata),
      .old_word   (old_word),
      .store_word (store_word),
      .load_data  (load_data),
      .err        (op_err)
   );

   // The array has no reset path, so a write is also blocked while reset is
   // held low; an aborted store must never land.
   assign mem_we = enter_resp && op_write && !op_err && reset;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[op_addr[DM_ADDRESS-1:2]] <= store_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         lat_write_reg <= 1'b0;
         lat_addr_reg  <= '0;
         lat_wdata_reg <= '0;
         lat_func3_reg <= 3'd0;
         req_ready_reg <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         rsp_valid_reg <= enter_resp;
         if (enter_resp) begin
            rsp_rdata_reg <= load_data;
            rsp_err_reg   <= op_err;
         end
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  lat_write_reg <= req_write;
                  lat_addr_reg  <= req_addr;
                  lat_wdata_reg <= req_wdata;
                  lat_func3_reg <= req_func3;
                  req_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state_reg <= RESP;
                  end else begin
                     state_reg <= WAIT;
                     cnt_reg   <= WAIT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_reg == 4'd0) begin
                  state_reg <= RESP;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            RESP: begin
               state_reg     <= IDLE;
               req_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
            end
            default: begin
               state_reg     <= IDLE;
               req_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a WAIT_CYCLES=2 instance takes directed and random
// traffic against a byte-array model; a WAIT_CYCLES=0 instance checks the
// back-to-back handshake cadence.
module tb_dmem_responder;

   localparam int W2 = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        a_valid = 1'b0, a_write = 1'b0;
   logic [8:0]  a_addr = '0;
   logic [31:0] a_wdata = '0;
   logic [2:0]  a_func3 = '0;
   logic        a_ready, a_rsp_valid, a_rsp_err, a_busy;
   logic [31:0] a_rsp_rdata;

   logic        z_valid = 1'b0, z_write = 1'b0;
   logic [8:0]  z_addr = '0;
   logic [31:0] z_wdata = '0;
   logic [2:0]  z_func3 = '0;
   logic        z_ready, z_rsp_valid, z_rsp_err, z_busy;
   logic [31:0] z_rsp_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mem_b [0:511];

   always #5 clk = ~clk;

   dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(W2)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
      .req_addr(a_addr), .req_wdata(a_wdata), .req_func3(a_func3),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
      .busy(a_busy)
   );

   dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut_z (
      .clk(clk), .reset(reset),
      .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
      .req_addr(z_addr), .req_wdata(z_wdata), .req_func3(z_func3),
      .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
      .busy(z_busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Reference: memory as bytes, access size and legality from funct3.
   task automatic model_op(input bit wr, input int a, input logic [31:0] wd,
                           input logic [2:0] f3, output logic [31:0] rd, output bit err);
      int size;
      bit sgn, legal;
      logic [31:0] v;
      size = 4; sgn = 0; legal = 1;
      case (f3)
         3'd0: begin size = 1; sgn = 1; end
         3'd1: begin size = 2; sgn = 1; end
         3'd2: size = 4;
         3'd4: begin size = 1; legal = !wr; end
         3'd5: begin size = 2; legal = !wr; end
         default: legal = 0;
      endcase
      err = !legal || ((a % size) != 0);
      rd  = 32'd0;
      if (!err) begin
         if (wr) begin
            for (int i = 0; i < size; i++) mem_b[a + i] = wd[8*i +: 8];
         end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
            if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            rd = v;
         end
      end
   endtask

   // One request on dut_a: bounded wait for ready, accept, check latency,
   // single-cycle pulse and payload.
   task automatic do_req(input bit wr, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [31:0] exp_rd, input bit exp_err);
      int guard, lat;
      guard = 0;
      while (!a_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      check_val("ready_before_req", 32'(a_ready), 32'd1);
      a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd; a_func3 = f3;
      @(posedge clk); #1;
      a_valid = 1'b0; a_write = $urandom_range(0, 1); a_addr = 9'($urandom);
      a_wdata = $urandom; a_func3 = 3'($urandom);
      check_val("busy_after_accept", 32'(a_busy), 32'd1);
      lat = 0;
      while (!a_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      check_val("latency", 32'(lat), 32'(W2));
      check_val("ready_in_resp", 32'(a_ready), 32'd0);
      check_val("rdata", a_rsp_rdata, exp_rd);
      check_val("err", 32'(a_rsp_err), 32'(exp_err));
      $display("txn %s addr=%h f3=%0d wdata=%h -> rdata=%h err=%0b lat=%0d",
               wr ? "ST" : "LD", addr, f3, wd, a_rsp_rdata, a_rsp_err, lat);
      @(posedge clk); #1;
      check_val("pulse_one_cycle", 32'(a_rsp_valid), 32'd0);
      check_val("ready_after_resp", 32'(a_ready), 32'd1);
      check_val("rdata_held", a_rsp_rdata, exp_rd);
   endtask

   // Directed access: update the model, check against the given constants.
   task automatic dir_req(input bit wr, input logic [8:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input logic [31:0] exp_rd, input bit exp_err);
      logic [31:0] mrd;
      bit merr;
      model_op(wr, int'(addr), wd, f3, mrd, merr);
      do_req(wr, addr, wd, f3, exp_rd, exp_err);
   endtask

   task automatic rnd_req(input bit wr, input logic [8:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3);
      logic [31:0] mrd;
      bit merr;
      model_op(wr, int'(addr), wd, f3, mrd, merr);
      do_req(wr, addr, wd, f3, mrd, merr);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_ready"}, 32'(a_ready), 32'd1);
      check_val({tag, "_rsp_valid"}, 32'(a_rsp_valid), 32'd0);
      check_val({tag, "_rdata"}, a_rsp_rdata, 32'd0);
      check_val({tag, "_err"}, 32'(a_rsp_err), 32'd0);
      check_val({tag, "_busy"}, 32'(a_busy), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b1;
      @(posedge clk); #1;

      // Fill words 0..15 so every later load hits known data.
      for (int w = 0; w < 16; w++) rnd_req(1'b1, 9'(w * 4), $urandom, 3'd2);

      dir_req(1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0);
      dir_req(1'b0, 9'h010, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0);
      dir_req(1'b0, 9'h013, 32'h0, 3'd0, 32'hFFFFFFDE, 1'b0);
      dir_req(1'b0, 9'h013, 32'h0, 3'd4, 32'h000000DE, 1'b0);
      dir_req(1'b0, 9'h012, 32'h0, 3'd1, 32'hFFFFDEAD, 1'b0);
      dir_req(1'b0, 9'h010, 32'h0, 3'd5, 32'h0000BEEF, 1'b0);
      dir_req(1'b1, 9'h011, 32'h00000055, 3'd0, 32'h0, 1'b0);
      dir_req(1'b0, 9'h010, 32'h0, 3'd2, 32'hDEAD55EF, 1'b0);
      dir_req(1'b1, 9'h012, 32'h00001234, 3'd1, 32'h0, 1'b0);
      dir_req(1'b0, 9'h010, 32'h0, 3'd2, 32'h123455EF, 1'b0);
      dir_req(1'b0, 9'h011, 32'h0, 3'd2, 32'h0, 1'b1);
      dir_req(1'b1, 9'h013, 32'h0000FFFF, 3'd1, 32'h0, 1'b1);
      dir_req(1'b0, 9'h010, 32'h0, 3'd2, 32'h123455EF, 1'b0);
      dir_req(1'b0, 9'h010, 32'h0, 3'd3, 32'h0, 1'b1);
      dir_req(1'b1, 9'h014, 32'hCAFEF00D, 3'd4, 32'h0, 1'b1);

      // Zero-wait instance: request held for 6 cycles -> alternating pulses.
      z_valid = 1'b1; z_write = 1'b1; z_addr = 9'h040; z_wdata = 32'h5A5A5A5A; z_func3 = 3'd2;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         check_val("z_rsp_valid", 32'(z_rsp_valid), 32'((c % 2) == 0));
         check_val("z_ready", 32'(z_ready), 32'((c % 2) != 0));
         $display("txn Z cycle=%0d rsp_valid=%0b ready=%0b", c, z_rsp_valid, z_ready);
      end
      z_write = 1'b0;
      @(posedge clk); #1;
      z_valid = 1'b0;
      check_val("z_load_pulse", 32'(z_rsp_valid), 32'd1);
      check_val("z_load_data", z_rsp_rdata, 32'h5A5A5A5A);
      check_val("z_load_err", 32'(z_rsp_err), 32'd0);

      // Reset aborts an in-flight store.
      dir_req(1'b1, 9'h020, 32'h11111111, 3'd2, 32'h0, 1'b0);
      dir_req(1'b0, 9'h020, 32'h0, 3'd2, 32'h11111111, 1'b0);
      a_valid = 1'b1; a_write = 1'b1; a_addr = 9'h020; a_wdata = 32'hAAAAAAAA; a_func3 = 3'd2;
      @(posedge clk); #1;
      a_valid = 1'b0;
      check_val("abort_busy", 32'(a_busy), 32'd1);
      reset = 1'b0;
      #1;
      check_reset_outputs("abort");
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check_val("abort_no_rsp", 32'(a_rsp_valid), 32'd0);
      end
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check_val("post_abort_no_rsp", 32'(a_rsp_valid), 32'd0);
      end
      $display("txn RESET abort of ST addr=020");
      dir_req(1'b0, 9'h020, 32'h0, 3'd2, 32'h11111111, 1'b0);

      // Random traffic in the initialised region.
      for (int i = 0; i < 60; i++) begin
         rnd_req(1'($urandom_range(0, 1)), 9'($urandom_range(0, 63)), $urandom,
                 3'($urandom_range(0, 7)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
